stack_alu_sequencer: RTL and testbench

- Controller that sequences the stack processor's operand stack and ALU.
- Accepts one command at a time over a valid/ready handshake: push, pop, arithmetic/logic, dup, swap.
- Runs each command through a fixed FETCH/EXEC/WB pipeline of states.
- Presents the top two stack entries to the rest of the processor and raises sticky overflow/underflow flags.

---
 rtl/stack_alu_sequencer_if.sv | 15 +
 rtl/stack_alu_sequencer.sv | 137 +++++++++++++
 tb/tb_stack_alu_sequencer.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/stack_alu_sequencer_if.sv
// stack_alu_sequencer_if: command handshake bundle for the stack ALU sequencer
//   cmd_valid  requester has a command on cmd_op/getin
//   cmd_ready  sequencer can accept a command this cycle
//   cmd_op     opcode (0 NOP,1 PUSH,2 POP,3 ADD,4 SUB,5 AND,6 DUP,7 SWAP)
//   getin      push data, sampled at acceptance
interface stack_alu_sequencer_if #(
    parameter int WIDTH = 16
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [WIDTH-1:0] getin;
    modport master (output cmd_valid, cmd_op, getin, input cmd_ready);
    modport slave  (input cmd_valid, cmd_op, getin, output cmd_ready);
endinterface

// File: rtl/stack_alu_sequencer.sv
// stack_alu_sequencer: sequences an operand stack and ALU through IDLE/FETCH/EXEC/WB
//   CLK              rising-edge clock
//   reset            asynchronous active-low reset
//   cmd              command handshake (slave side)
//   err_clr          clears sticky overflow/underflow
//   top_of_stack     entry[count-1], 0 when empty
//   second_of_stack  entry[count-2], 0 when count<2
//   depth_count      number of valid entries
//   done             one-cycle pulse after the WB edge
//   overflow         sticky: PUSH/DUP on a full stack
//   underflow        sticky: op with too few entries
module stack_alu_sequencer #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    parameter int CNT_W = 4
) (
    input  logic                 CLK,
    input  logic                 reset,
    stack_alu_sequencer_if.slave cmd,
    input  logic                 err_clr,
    output logic [WIDTH-1:0]     top_of_stack,
    output logic [WIDTH-1:0]     second_of_stack,
    output logic [CNT_W-1:0]     depth_count,
    output logic                 done,
    output logic                 overflow,
    output logic                 underflow
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [2:0] OP_PUSH = 3'd1, OP_POP = 3'd2, OP_ADD = 3'd3, OP_SUB = 3'd4,
                           OP_AND = 3'd5, OP_DUP = 3'd6, OP_SWAP = 3'd7;
    typedef enum logic [1:0] {IDLE, FETCH, EXEC, WB} state_t;
    state_t           state, state_nx;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [CNT_W-1:0] count, count_nx;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] din_q, a_q, b_q, res_q;
    logic             ok_q, ovf_q, unf_q;
    logic             accept, full, ovf_c, unf_c, commit, grow, shrink;
    logic [AW-1:0]    i0, i1, i2;
    logic             we_a, we_b;
    logic [AW-1:0]    ia;
    logic [WIDTH-1:0] da;

    // Slots for the next free entry, the top and the second entry.
    assign i0 = AW'(count);
    assign i1 = AW'(count - CNT_W'(1));
    assign i2 = AW'(count - CNT_W'(2));
    assign top_of_stack    = (count == '0) ? '0 : mem[i1];
    assign second_of_stack = (count < CNT_W'(2)) ? '0 : mem[i2];
    assign depth_count     = count;
    assign cmd.cmd_ready   = state == IDLE;
    assign accept          = cmd.cmd_valid && cmd.cmd_ready;
    assign full            = count == CNT_W'(DEPTH);

    always_comb begin
        ovf_c = 1'b0;
        unf_c = 1'b0;
        case (cmd.cmd_op)
            OP_PUSH: ovf_c = full;
            OP_POP:  unf_c = count == '0;
            OP_DUP: begin
                ovf_c = full;
                unf_c = count == '0;
            end
            OP_ADD, OP_SUB, OP_AND, OP_SWAP: unf_c = count < CNT_W'(2);
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge reset)
        if (!reset) state <= IDLE;
        else        state <= state_nx;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = accept ? FETCH : IDLE;
            FETCH:   state_nx = EXEC;
            EXEC:    state_nx = WB;
            default: state_nx = IDLE;
        endcase
    end

    // Write port A covers every single-entry update; port B is only the second half of SWAP.
    always_comb begin
        commit   = state == WB && ok_q;
        grow     = op_q == OP_PUSH || op_q == OP_DUP;
        shrink   = op_q == OP_POP || op_q == OP_ADD || op_q == OP_SUB || op_q == OP_AND;
        we_a     = commit && op_q != OP_POP && op_q != 3'd0;
        we_b     = commit && op_q == OP_SWAP;
        ia       = grow ? i0 : (op_q == OP_SWAP) ? i1 : i2;
        da       = (op_q == OP_PUSH) ? din_q : (op_q == OP_DUP) ? a_q : (op_q == OP_SWAP) ? b_q : res_q;
        count_nx = !commit ? count : grow ? count + CNT_W'(1) : shrink ? count - CNT_W'(1) : count;
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_mem
        always_ff @(posedge CLK or negedge reset)
            if (!reset) mem[g] <= '0;
            else        mem[g] <= (we_a && ia == AW'(g)) ? da : (we_b && i2 == AW'(g)) ? a_q : mem[g];
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            count     <= '0;
            op_q      <= '0;
            din_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            res_q     <= '0;
            ok_q      <= 1'b0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
            done      <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            count <= count_nx;
            done  <= state == WB;
            if (accept) begin
                op_q  <= cmd.cmd_op;
                din_q <= cmd.getin;
                ok_q  <= !(ovf_c || unf_c);
                ovf_q <= ovf_c;
                unf_q <= unf_c;
            end
            if (state == FETCH) begin
                a_q <= top_of_stack;
                b_q <= second_of_stack;
            end
            if (state == EXEC)
                res_q <= (op_q == OP_ADD) ? b_q + a_q : (op_q == OP_SUB) ? b_q - a_q : b_q & a_q;
            // A flag raised on the WB edge wins over a simultaneous clear.
            overflow  <= (state == WB && ovf_q) || (overflow && !err_clr);
            underflow <= (state == WB && unf_q) || (underflow && !err_clr);
        end
    end
endmodule

// File: tb/tb_stack_alu_sequencer.sv
// tb_stack_alu_sequencer: directed self-checking bench for stack_alu_sequencer
module tb_stack_alu_sequencer;
    logic        CLK = 1'b0;
    logic        reset;
    logic        err_clr;
    logic [15:0] top_of_stack, second_of_stack;
    logic [3:0]  depth_count;
    logic        done, overflow, underflow;
    int          checks = 0;
    int          errors = 0;

    stack_alu_sequencer_if #(.WIDTH(16)) bus ();

    stack_alu_sequencer dut (
        .CLK             (CLK),
        .reset           (reset),
        .cmd             (bus),
        .err_clr         (err_clr),
        .top_of_stack    (top_of_stack),
        .second_of_stack (second_of_stack),
        .depth_count     (depth_count),
        .done            (done),
        .overflow        (overflow),
        .underflow       (underflow)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present a command for one edge, then scramble op/data to show they are ignored.
    task automatic start(input logic [2:0] op, input logic [15:0] d);
        chk("ready_idle", bus.cmd_ready, 1);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.getin     = d;
        @(posedge CLK); #1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 3'd7;
        bus.getin     = 16'hDEAD;
    endtask

    task automatic cmd(input logic [2:0] op, input logic [15:0] d);
        start(op, d);
        for (int i = 0; i < 3; i++) begin
            chk("busy_ready", bus.cmd_ready, 0);
            chk("busy_done", done, 0);
            @(posedge CLK); #1;
        end
        chk("done_pulse", done, 1);
        chk("ready_at_done", bus.cmd_ready, 1);
    endtask

    initial begin
        reset = 1'b0;
        err_clr = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_op = 3'd0;
        bus.getin = 16'h0;
        repeat (3) @(posedge CLK);
        #1 reset = 1'b1;
        chk("rst_ready", bus.cmd_ready, 1);
        chk("rst_done", done, 0);
        chk("rst_count", depth_count, 0);
        chk("rst_top", top_of_stack, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_unf", underflow, 0);

        cmd(3'd1, 16'd4);
        cmd(3'd1, 16'd2);
        chk("push2_top", top_of_stack, 16'd2);
        chk("push2_second", second_of_stack, 16'd4);
        cmd(3'd4, 16'h0);
        chk("sub_top", top_of_stack, 16'd2);
        chk("sub_count", depth_count, 1);
        chk("sub_second", second_of_stack, 0);

        cmd(3'd2, 16'h0);
        chk("pop_count", depth_count, 0);
        cmd(3'd1, 16'hFFFF);
        cmd(3'd1, 16'h0002);
        cmd(3'd3, 16'h0);
        chk("add_wrap_top", top_of_stack, 16'h0001);
        chk("add_count", depth_count, 1);
        cmd(3'd6, 16'h0);
        chk("dup_top", top_of_stack, 16'h0001);
        chk("dup_second", second_of_stack, 16'h0001);
        chk("dup_count", depth_count, 2);
        cmd(3'd5, 16'h0);
        chk("and_top", top_of_stack, 16'h0001);
        chk("and_second", second_of_stack, 0);
        chk("and_count", depth_count, 1);

        cmd(3'd2, 16'h0);
        cmd(3'd2, 16'h0);
        chk("pop_empty_unf", underflow, 1);
        chk("pop_empty_ovf", overflow, 0);
        chk("pop_empty_count", depth_count, 0);
        chk("pop_empty_top", top_of_stack, 0);
        err_clr = 1'b1;
        @(posedge CLK); #1 err_clr = 1'b0;
        chk("clr_unf", underflow, 0);

        for (int v = 1; v <= 8; v++) cmd(3'd1, 16'(v));
        chk("full_count", depth_count, 8);
        chk("full_ovf_clean", overflow, 0);
        cmd(3'd1, 16'd9);
        chk("ovf_flag", overflow, 1);
        chk("ovf_unf", underflow, 0);
        chk("ovf_count", depth_count, 8);
        chk("ovf_top", top_of_stack, 16'd8);
        chk("ovf_second", second_of_stack, 16'd7);
        cmd(3'd7, 16'h0);
        chk("swap_top", top_of_stack, 16'd7);
        chk("swap_second", second_of_stack, 16'd8);
        chk("swap_count", depth_count, 8);

        reset = 1'b0;
        @(posedge CLK); #1 reset = 1'b1;
        chk("rst2_count", depth_count, 0);
        chk("rst2_ovf", overflow, 0);
        cmd(3'd1, 16'h00AA);
        chk("aa_top", top_of_stack, 16'h00AA);
        start(3'd1, 16'h0055);
        @(posedge CLK); #1;
        reset = 1'b0;
        #1;
        chk("mid_rst_count", depth_count, 0);
        chk("mid_rst_top", top_of_stack, 0);
        chk("mid_rst_ready", bus.cmd_ready, 1);
        chk("mid_rst_done", done, 0);
        @(negedge CLK) reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge CLK); #1;
            chk("no_stale_done", done, 0);
            chk("no_stale_count", depth_count, 0);
        end
        cmd(3'd1, 16'd3);
        chk("after_rst_top", top_of_stack, 16'd3);
        chk("after_rst_count", depth_count, 1);

        cmd(3'd2, 16'h0);
        cmd(3'd2, 16'h0);
        chk("unf_again", underflow, 1);
        start(3'd2, 16'h0);
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        err_clr = 1'b1;
        @(posedge CLK); #1 err_clr = 1'b0;
        chk("same_edge_done", done, 1);
        chk("same_edge_unf", underflow, 1);
        err_clr = 1'b1;
        @(posedge CLK); #1 err_clr = 1'b0;
        chk("clr2_unf", underflow, 0);
        cmd(3'd6, 16'h0);
        chk("dup_empty_unf", underflow, 1);
        chk("dup_empty_ovf", overflow, 0);
        chk("dup_empty_count", depth_count, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
